// File: rtl/reg_file.sv
// Multi-entry register file: one byte-maskable write port, two registered read ports.
// Define REGFILE_BYPASS_EN for write-through forwarding on read/write address collisions.
module reg_file #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned AW      = 3,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic               clk,
    input  logic               res,
    input  logic               en,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic               ren_a,
    input  logic [AW-1:0]      raddr_a,
    output logic [WIDTH-1:0]   rdata_a,
    input  logic               ren_b,
    input  logic [AW-1:0]      raddr_b,
    output logic [WIDTH-1:0]   rdata_b
);

    localparam int unsigned NB    = WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] merged;
    logic             wr_act;
    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] nxt_b;

    // Post-write word: old entry with the enabled byte lanes replaced.
    always_comb begin
        merged = mem[waddr];
        for (int unsigned i = 0; i < NB; i++) begin
            if (wbe[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    assign wr_act = we && (wbe != '0) && !(ZERO_R0 && (waddr == '0));

    always_comb begin
        nxt_a = mem[raddr_a];
        nxt_b = mem[raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_act && (raddr_a == waddr)) begin
            nxt_a = merged;
        end
        if (wr_act && (raddr_b == waddr)) begin
            nxt_b = merged;
        end
`endif
        if (ZERO_R0 && (raddr_a == '0)) begin
            nxt_a = '0;
        end
        if (ZERO_R0 && (raddr_b == '0)) begin
            nxt_b = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            mem     <= '{default: '0};
            rdata_a <= '0;
            rdata_b <= '0;
        end else if (en) begin
            if (wr_act) begin
                mem[waddr] <= merged;
            end
            if (ren_a) begin
                rdata_a <= nxt_a;
            end
            if (ren_b) begin
                rdata_b <= nxt_b;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: an array-based model checked every cycle against two
// instances (ZERO_R0=0 and ZERO_R0=1) sharing stimulus, plus literal checks on the directed cases.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        res, en, we, ren_a, ren_b;
    logic [2:0]  waddr, raddr_a, raddr_b;
    logic [15:0] wdata;
    logic [1:0]  wbe;
    logic [15:0] rdata_a, rdata_b, zdata_a, zdata_b;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    reg_file #(.WIDTH(16), .AW(3), .ZERO_R0(1'b0)) dut (
        .clk(clk), .res(res), .en(en), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
        .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(rdata_b)
    );

    reg_file #(.WIDTH(16), .AW(3), .ZERO_R0(1'b1)) dut_z (
        .clk(clk), .res(res), .en(en), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(zdata_a),
        .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(zdata_b)
    );

    // Model: plain arrays for the two storage variants and their expected read registers.
    logic [15:0] mm [8];
    logic [15:0] mz [8];
    logic [15:0] pre_m [8];
    logic [15:0] pre_z [8];
    logic [15:0] ea = '0, eb = '0, eza = '0, ezb = '0;

    always @(posedge clk) begin
        if (!res) begin
            for (int i = 0; i < 8; i++) begin
                mm[i] = 16'h0000;
                mz[i] = 16'h0000;
            end
            ea = 0; eb = 0; eza = 0; ezb = 0;
        end else if (en) begin
            pre_m = mm;
            pre_z = mz;
            if (we) begin
                for (int b = 0; b < 2; b++) begin
                    if (wbe[b]) begin
                        mm[waddr][8*b +: 8] = wdata[8*b +: 8];
                        if (waddr != 0) mz[waddr][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end
`ifdef REGFILE_BYPASS_EN
            if (ren_a) begin ea = mm[raddr_a]; eza = (raddr_a == 0) ? 16'h0 : mz[raddr_a]; end
            if (ren_b) begin eb = mm[raddr_b]; ezb = (raddr_b == 0) ? 16'h0 : mz[raddr_b]; end
`else
            if (ren_a) begin ea = pre_m[raddr_a]; eza = (raddr_a == 0) ? 16'h0 : pre_z[raddr_a]; end
            if (ren_b) begin eb = pre_m[raddr_b]; ezb = (raddr_b == 0) ? 16'h0 : pre_z[raddr_b]; end
`endif
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("cyc_rdata_a", rdata_a, ea);
            check("cyc_rdata_b", rdata_b, eb);
            check("cyc_zdata_a", zdata_a, eza);
            check("cyc_zdata_b", zdata_b, ezb);
        end
    end

    task automatic cyc(input logic r, input logic e, input logic w, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [1:0] be,
                       input logic ra_en, input logic [2:0] ra,
                       input logic rb_en, input logic [2:0] rb);
        res = r; en = e; we = w; waddr = wa; wdata = wd; wbe = be;
        ren_a = ra_en; raddr_a = ra; ren_b = rb_en; raddr_b = rb;
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        cyc(1, 1, 1, a, d, be, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [2:0] b);
        cyc(1, 1, 0, 0, 16'h0, 2'b00, 1, a, 1, b);
    endtask

    initial begin
        // Reset held two edges with a write pending
        cyc(0, 1, 1, 3'd1, 16'hFFFF, 2'b11, 1, 0, 1, 0);
        started = 1'b1;
        cyc(0, 1, 1, 3'd1, 16'hFFFF, 2'b11, 1, 0, 1, 0);
        check("rst_a", rdata_a, 16'h0000);
        check("rst_b", rdata_b, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 3'(7 - i));
            check("rst_entry", rdata_a, 16'h0000);
        end

        // Full write then read, one cycle latency
        wr(3'd3, 16'hF00F, 2'b11);
        rd(3'd3, 3'd3);
        check("wr_rd_a", rdata_a, 16'hF00F);
        check("wr_rd_b", rdata_b, 16'hF00F);

        // en=0 blocks the write and freezes outputs
        cyc(1, 0, 1, 3'd2, 16'hF0AA, 2'b11, 1, 3'd2, 1, 3'd2);
        check("en0_hold_a", rdata_a, 16'hF00F);
        check("en0_hold_b", rdata_b, 16'hF00F);
        rd(3'd2, 3'd0);
        check("en0_nowrite", rdata_a, 16'h0000);

        // Byte-masked write
        wr(3'd5, 16'h0FAA, 2'b11);
        wr(3'd5, 16'h1234, 2'b01);
        rd(3'd5, 3'd3);
        check("mask_lo", rdata_a, 16'h0F34);
        wr(3'd5, 16'hAB00, 2'b10);
        wr(3'd5, 16'hFFFF, 2'b00);
        rd(3'd3, 3'd5);
        check("mask_hi_none", rdata_b, 16'hAB34);

        // Same-edge collision on both ports
        wr(3'd4, 16'h00FF, 2'b11);
        cyc(1, 1, 1, 3'd4, 16'hABCD, 2'b11, 1, 3'd4, 1, 3'd4);
`ifdef REGFILE_BYPASS_EN
        check("coll_a", rdata_a, 16'hABCD);
        check("coll_b", rdata_b, 16'hABCD);
`else
        check("coll_a", rdata_a, 16'h00FF);
        check("coll_b", rdata_b, 16'h00FF);
`endif
        rd(3'd4, 3'd4);
        check("coll_after", rdata_a, 16'hABCD);

        // Partial-lane collision
        cyc(1, 1, 1, 3'd4, 16'h1199, 2'b10, 1, 3'd4, 0, 3'd0);
`ifdef REGFILE_BYPASS_EN
        check("coll_part", rdata_a, 16'h11CD);
`else
        check("coll_part", rdata_a, 16'hABCD);
`endif

        // Entry 0 on the ZERO_R0 instance
        wr(3'd0, 16'h5555, 2'b11);
        rd(3'd0, 3'd0);
        check("z_r0_b", zdata_b, 16'h0000);
        check("r0_plain", rdata_b, 16'h5555);
        cyc(1, 1, 1, 3'd0, 16'h7777, 2'b11, 1, 3'd0, 1, 3'd0);
        check("z_r0_coll", zdata_b, 16'h0000);

        // Assorted writes, checked by the per-cycle compare
        for (int i = 1; i < 8; i++) begin
            wr(3'(i), 16'(i * 16'h1111 + 16'h0102), 2'(i));
            rd(3'(i), 3'(8 - i));
        end

        // Reset mid-write discards the write and clears everything
        cyc(0, 1, 1, 3'd6, 16'hBEEF, 2'b11, 1, 3'd6, 1, 3'd6);
        check("rst2_a", rdata_a, 16'h0000);
        check("rst2_zb", zdata_b, 16'h0000);
        rd(3'd6, 3'd7);
        check("rst2_e6", rdata_a, 16'h0000);
        check("rst2_e7", rdata_b, 16'h0000);
        rd(3'd0, 3'd5);
        check("rst2_e0", rdata_a, 16'h0000);

        cyc(1, 1, 0, 0, 16'h0, 2'b00, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
